alu_pipe: RTL and testbench

- Parametrised, handshaked successor to the processor's combinational execute ALU.
- Accepts one operation per cycle on a valid/ready input channel and registers the result and flags.
- Non-multiply ops complete in 1 cycle; MUL runs an iterative shift-add over WIDTH cycles.
- Sits in the EX stage; the output channel stalls the pipeline via out_ready.

---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu_mul_seq.sv | 56 +++++
 rtl/alu_pipe.sv | 124 ++++++++++++
 tb/tb_alu_pipe.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode and FSM state types for the pipelined execute ALU.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_MUL = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_AND = 3'b101,
    OP_SLT = 3'b110,
    OP_RSV = 3'b111
  } op_t;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_MUL_BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: start captures a/b, done pulses WIDTH cycles later
// with product valid combinationally in that same cycle; no backpressure (caller owns flow control).
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  logic             running;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;

  // mcand is pre-shifted by cnt and mplier[0] is the original bit[cnt]
  always_comb begin
    acc_next = acc;
    if (mplier[0]) acc_next = acc + mcand;
  end

  assign done    = running && (cnt == CNT_W'(WIDTH - 1));
  assign product = acc_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running <= 1'b0;
      cnt     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
    end else if (start) begin
      running <= 1'b1;
      cnt     <= '0;
      mcand   <= a;
      mplier  <= b;
      acc     <= '0;
    end else if (running) begin
      acc     <= acc_next;
      mcand   <= mcand << 1;
      mplier  <= mplier >> 1;
      cnt     <= cnt + CNT_W'(1);
      running <= !done;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked EX-stage ALU: 1-cycle latency for logic/add ops, WIDTH cycles for MUL.
// A held result (out_valid && !out_ready) blocks new accepts; MUL blocks accepts until done.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic             src_imm,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero_flag,
  output logic             ne_flag,
  output logic             even_flag,
  output logic             busy
);

  state_t           state, state_n;
  op_t              opc;
  logic [WIDTH-1:0] b_opnd;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] ld_val;
  logic [WIDTH-1:0] mul_prod;
  logic             accept;
  logic             ld;
  logic             ov_n;
  logic             mul_start;
  logic             mul_done;

  assign opc      = op_t'(op);
  assign b_opnd   = src_imm ? imm : in_b;
  assign in_ready = (state == ST_IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign busy     = (state == ST_MUL_BUSY);
  assign ne_flag  = ~zero_flag;

  always_comb begin
    alu_res = '0;
    case (opc)
      OP_ADD:  alu_res = in_a + b_opnd;
      OP_SUB:  alu_res = b_opnd - in_a;
      OP_OR:   alu_res = in_a | b_opnd;
      OP_XOR:  alu_res = in_a ^ b_opnd;
      OP_AND:  alu_res = in_a & b_opnd;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(in_a) < $signed(b_opnd))};
      default: alu_res = '0;
    endcase
  end

  alu_mul_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (in_a),
    .b       (b_opnd),
    .done    (mul_done),
    .product (mul_prod)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_n;
  end

  // A consumed result drops out_valid unless a new one loads on the same edge
  always_comb begin
    state_n   = state;
    ov_n      = out_valid && !out_ready;
    ld        = 1'b0;
    ld_val    = '0;
    mul_start = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (opc == OP_MUL) begin
            state_n   = ST_MUL_BUSY;
            mul_start = 1'b1;
            ov_n      = 1'b0;
          end else begin
            ld     = 1'b1;
            ld_val = alu_res;
            ov_n   = 1'b1;
          end
        end
      end
      ST_MUL_BUSY: begin
        if (mul_done) begin
          state_n = ST_IDLE;
          ld      = 1'b1;
          ld_val  = mul_prod;
          ov_n    = 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Flags come from ld_val so they move in the same edge as result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      zero_flag <= 1'b1;
      even_flag <= 1'b1;
    end else begin
      out_valid <= ov_n;
      if (ld) begin
        result    <= ld_val;
        zero_flag <= (ld_val == '0);
        even_flag <= ~ld_val[0];
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed scenarios plus a randomized stream checked against an arithmetic reference model.
module tb_alu_pipe;

  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, MUL = 3'd2, ORR = 3'd3,
                         XOR = 3'd4, ANDD = 3'd5, SLT = 3'd6;

  logic        clk, rst_n, in_valid, in_ready, src_imm, out_valid, out_ready;
  logic [2:0]  op;
  logic [31:0] in_a, in_b, imm, result;
  logic        zero_flag, ne_flag, even_flag, busy;
  int          errors = 0;
  int          checks = 0;

  alu_pipe #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .src_imm(src_imm), .in_a(in_a), .in_b(in_b), .imm(imm), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero_flag(zero_flag), .ne_flag(ne_flag),
    .even_flag(even_flag), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_alu(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    case (o)
      ADD:     return a + b;
      SUB:     return b - a;
      MUL:     return a * b;
      ORR:     return a | b;
      XOR:     return a ^ b;
      ANDD:    return a & b;
      SLT:     return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 4))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic drive(input logic v, input logic [2:0] o, input logic s,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] im);
    in_valid = v; op = o; src_imm = s; in_a = a; in_b = b; imm = im;
  endtask

  task automatic test_reset();
    @(negedge clk); out_ready = 1'b1; drive(1, ADD, 0, 32'd1, 32'd2, 32'd0);
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || result !== 32'd3) begin errors++;
      $display("FAIL pre_reset_add: out_valid=%b result=%h, need 1/00000003", out_valid, result); end
    drive(1, ADD, 0, 32'd4, 32'd5, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || result !== 32'd0) begin errors++;
      $display("FAIL reset_outputs: out_valid=%b result=%h, need 0/0", out_valid, result); end
    checks++; if (zero_flag !== 1'b1 || ne_flag !== 1'b0 || even_flag !== 1'b1 || busy !== 1'b0) begin errors++;
      $display("FAIL reset_flags: z/ne/ev/busy=%b%b%b%b, need 1010", zero_flag, ne_flag, even_flag, busy); end
    in_valid = 1'b0;
    @(negedge clk); #2 rst_n = 1'b1; #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++;
      $display("FAIL post_release: in_ready=%b out_valid=%b, need 1/0", in_ready, out_valid); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || result !== 32'd0) begin errors++;
      $display("FAIL post_release_idle: out_valid=%b result=%h, need 0/0", out_valid, result); end
  endtask

  task automatic test_sub_add();
    @(negedge clk); out_ready = 1'b1; drive(1, SUB, 0, 32'd5, 32'd3, 32'd0);
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || result !== 32'hFFFF_FFFE) begin errors++;
      $display("FAIL sub_result: out_valid=%b result=%h, need 1/fffffffe", out_valid, result); end
    checks++; if (zero_flag !== 1'b0 || ne_flag !== 1'b1 || even_flag !== 1'b1) begin errors++;
      $display("FAIL sub_flags: z/ne/ev=%b%b%b, need 011", zero_flag, ne_flag, even_flag); end
    drive(1, ADD, 0, 32'hFFFF_FFFF, 32'd1, 32'd0);
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || result !== 32'd0 || zero_flag !== 1'b1 || ne_flag !== 1'b0) begin errors++;
      $display("FAIL add_wrap: out_valid=%b result=%h z=%b ne=%b, need 1/0/1/0", out_valid, result, zero_flag, ne_flag); end
    in_valid = 1'b0;
  endtask

  task automatic test_imm_slt();
    @(negedge clk); out_ready = 1'b1; drive(1, XOR, 1, 32'h0000_00F0, 32'h0000_DEAD, 32'h0000_000F);
    @(negedge clk);
    checks++; if (result !== 32'h0000_00FF || even_flag !== 1'b0 || zero_flag !== 1'b0) begin errors++;
      $display("FAIL xor_imm: result=%h even=%b zero=%b, need 000000ff/0/0", result, even_flag, zero_flag); end
    drive(1, SLT, 0, 32'hFFFF_FFFF, 32'd1, 32'd0);
    @(negedge clk);
    checks++; if (result !== 32'd1 || out_valid !== 1'b1) begin errors++;
      $display("FAIL slt_neg: result=%h out_valid=%b, need 00000001/1", result, out_valid); end
    in_valid = 1'b0;
  endtask

  task automatic test_mul();
    int n = 0;
    int bad = 0;
    @(negedge clk); out_ready = 1'b1; drive(1, MUL, 0, 32'd7, 32'd6, 32'd0);
    @(posedge clk); #1 drive(1, ADD, 0, 32'd10, 32'd20, 32'd0);
    while (n < 40) begin
      @(negedge clk);
      if (out_valid) break;
      if (busy !== 1'b1 || in_ready !== 1'b0) bad++;
      @(posedge clk); n++;
    end
    checks++; if (n != 32) begin errors++;
      $display("FAIL mul_latency: cycles=%0d, need 32", n); end
    checks++; if (bad != 0) begin errors++;
      $display("FAIL mul_busy: %0d cycles without busy=1/in_ready=0, need 0", bad); end
    checks++; if (out_valid !== 1'b1 || result !== 32'd42 || busy !== 1'b0) begin errors++;
      $display("FAIL mul_result: out_valid=%b result=%0d busy=%b, need 1/42/0", out_valid, result, busy); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || result !== 32'd30) begin errors++;
      $display("FAIL held_after_mul: out_valid=%b result=%0d, need 1/30", out_valid, result); end
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int bad = 0;
    @(negedge clk); out_ready = 1'b1; drive(1, ADD, 0, 32'd100, 32'd1, 32'd0);
    @(negedge clk); out_ready = 1'b0; drive(1, ADD, 0, 32'd200, 32'd2, 32'd0); #1;
    checks++; if (out_valid !== 1'b1 || result !== 32'd101 || in_ready !== 1'b0) begin errors++;
      $display("FAIL bp_first: out_valid=%b result=%0d in_ready=%b, need 1/101/0", out_valid, result, in_ready); end
    repeat (3) begin
      @(negedge clk);
      if (result !== 32'd101 || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++;
      $display("FAIL bp_hold: %0d unstable cycles, need 0", bad); end
    out_ready = 1'b1; #1;
    checks++; if (in_ready !== 1'b1) begin errors++;
      $display("FAIL bp_release: in_ready=%b, need 1", in_ready); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || result !== 32'd202) begin errors++;
      $display("FAIL bp_second: out_valid=%b result=%0d, need 1/202", out_valid, result); end
    drive(1, ADD, 0, 32'd300, 32'd3, 32'd0);
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || result !== 32'd303) begin errors++;
      $display("FAIL bp_third: out_valid=%b result=%0d, need 1/303", out_valid, result); end
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || result !== 32'd303) begin errors++;
      $display("FAIL bp_drain: out_valid=%b result=%0d, need 0/303", out_valid, result); end
  endtask

  task automatic test_reset_mid_mul();
    int seen = 0;
    @(negedge clk); out_ready = 1'b1; drive(1, MUL, 0, 32'd9, 32'd5, 32'd0);
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0; #1;
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++;
      $display("FAIL mid_mul_reset: busy=%b out_valid=%b, need 0/0", busy, out_valid); end
    @(negedge clk); #2 rst_n = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || busy !== 1'b0) seen++;
    end
    checks++; if (seen != 0 || result !== 32'd0) begin errors++;
      $display("FAIL stale_result: %0d cycles valid/busy, result=%0d, need 0/0", seen, result); end
  endtask

  task automatic test_random();
    logic [31:0] exp_q[$];
    logic [31:0] e, b;
    int issued = 0;
    int cyc = 0;
    logic [2:0] o;
    logic acc;
    localparam int N = 60;
    while (cyc < 5000 && (issued < N || exp_q.size() != 0)) begin
      @(negedge clk); cyc++;
      out_ready = ($urandom_range(0, 3) != 0);
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin errors++;
          $display("FAIL rand_spurious: result=%h with no op outstanding", result);
        end else begin
          e = exp_q.pop_front();
          if (result !== e || zero_flag !== (e == 0) || ne_flag !== (e != 0) || even_flag !== ~e[0]) begin errors++;
            $display("FAIL rand_result: result=%h z/ne/ev=%b%b%b, need %h z/ne/ev=%b%b%b",
                     result, zero_flag, ne_flag, even_flag, e, (e == 0), (e != 0), ~e[0]);
          end
        end
      end
      if (!in_valid && issued < N && $urandom_range(0, 2) != 0) begin
        o = 3'($urandom_range(0, 7));
        if (o == MUL && $urandom_range(0, 2) != 0) o = XOR;
        drive(1, o, 1'($urandom_range(0, 1)), rnd_val(), rnd_val(), rnd_val());
      end
      #1;
      acc = in_valid && in_ready;
      if (acc) begin
        b = src_imm ? imm : in_b;
        exp_q.push_back(ref_alu(op, in_a, b));
        issued++;
      end
      @(posedge clk); #1;
      if (acc) in_valid = 1'b0;
    end
    checks++; if (issued != N || exp_q.size() != 0) begin errors++;
      $display("FAIL rand_drain: issued=%0d outstanding=%0d, need %0d/0", issued, exp_q.size(), N); end
    out_ready = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; out_ready = 1'b1;
    drive(0, ADD, 0, 32'd0, 32'd0, 32'd0);
    #12 rst_n = 1'b1;
    test_reset();
    test_sub_add();
    test_imm_slt();
    test_mul();
    test_backpressure();
    test_reset_mid_mul();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
